// File: rtl/flex_down_counter.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// Loads a start value, decrements on enabled cycles and flags the terminal count.
//
// state | meaning
// IDLE  | not counting; enables ignored, outputs hold
// RUN   | counting down on enabled cycles (busy=1)
// DONE  | one-shot expired; count_out=0, zero_flag=1 held until clear/load
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    zero_flag,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

  state_t                  state, state_nxt;
  logic [NUM_CNT_BITS-1:0] reload_reg, reload_nxt;
  logic [NUM_CNT_BITS-1:0] count_nxt;
  logic                    zero_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      count_out  <= ZERO;
      reload_reg <= ZERO;
      zero_flag  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_out  <= count_nxt;
      reload_reg <= reload_nxt;
      zero_flag  <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count_out;
    reload_nxt = reload_reg;
    zero_nxt   = zero_flag;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = ZERO;
      zero_nxt  = 1'b0;
    end else if (load) begin
      reload_nxt = load_val;
      count_nxt  = load_val;
      zero_nxt   = 1'b0;
      state_nxt  = (load_val != ZERO) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          // zero_flag is rewritten every RUN cycle so a reload tick lasts one edge
          zero_nxt = 1'b0;
          if (count_enable) begin
            if (count_out > ONE) begin
              count_nxt = count_out - ONE;
            end else if (auto_reload) begin
              count_nxt = reload_reg;
              zero_nxt  = 1'b1;
            end else begin
              count_nxt = ZERO;
              zero_nxt  = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        IDLE, DONE: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = ZERO;
          zero_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed bench for flex_down_counter: vector table plus hand-written
// sequences for full-range count, held terminal state and async reset.
module tb_flex_down_counter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear, load, count_enable, auto_reload;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       zero_flag, busy;

  int checks = 0;
  int errors = 0;

  flex_down_counter #(.NUM_CNT_BITS(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .count_out    (count_out),
    .zero_flag    (zero_flag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       ld;
    logic [3:0] val;
    logic       en;
    logic       ar;
    logic [3:0] e_cnt;
    logic       e_zero;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic clr, logic ld, logic [3:0] val,
                              logic en, logic ar, logic [3:0] e_cnt,
                              logic e_zero, logic e_busy);
    vec_t v;
    v.name = name; v.clr = clr; v.ld = ld; v.val = val; v.en = en; v.ar = ar;
    v.e_cnt = e_cnt; v.e_zero = e_zero; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(string name, logic [3:0] e_cnt, logic e_zero, logic e_busy);
    check({name, ".count"}, 32'(count_out), 32'(e_cnt));
    check({name, ".zero"},  32'(zero_flag), 32'(e_zero));
    check({name, ".busy"},  32'(busy),      32'(e_busy));
  endtask

  task automatic drive(logic clr, logic ld, logic [3:0] val, logic en, logic ar);
    @(negedge clk);
    clear = clr; load = ld; load_val = val; count_enable = en; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = 4'd0; count_enable = 1'b0; auto_reload = 1'b0;

    // one-shot from 4
    vecs.push_back(mk("os_load", 0, 1, 4, 1, 0, 4, 0, 1));
    vecs.push_back(mk("os_3",    0, 0, 0, 1, 0, 3, 0, 1));
    vecs.push_back(mk("os_2",    0, 0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk("os_1",    0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk("os_term", 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("os_hold", 0, 0, 0, 1, 0, 0, 1, 0));
    // auto-reload period 3
    vecs.push_back(mk("ar_load", 0, 1, 3, 1, 1, 3, 0, 1));
    vecs.push_back(mk("ar_2",    0, 0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(mk("ar_1",    0, 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk("ar_tick", 0, 0, 0, 1, 1, 3, 1, 1));
    vecs.push_back(mk("ar_2b",   0, 0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(mk("ar_1b",   0, 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk("ar_tick2",0, 0, 0, 1, 1, 3, 1, 1));
    vecs.push_back(mk("ar_gate", 0, 0, 0, 0, 1, 3, 0, 1));
    // gated enable from 2
    vecs.push_back(mk("g_load",  0, 1, 2, 0, 0, 2, 0, 1));
    vecs.push_back(mk("g_en1",   0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk("g_off1",  0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("g_en2",   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("g_off2",  0, 0, 0, 0, 0, 0, 1, 0));
    // priority
    vecs.push_back(mk("p_load7", 0, 1, 7, 0, 0, 7, 0, 1));
    vecs.push_back(mk("p_clear", 1, 1, 12, 1, 0, 0, 0, 0));
    vecs.push_back(mk("p_load9", 0, 1, 9, 1, 0, 9, 0, 1));
    vecs.push_back(mk("p_dec",   0, 0, 0, 1, 0, 8, 0, 1));
    // load of zero
    vecs.push_back(mk("z_load",  0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("z_en",    0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("z_en_ar", 0, 0, 0, 1, 1, 0, 0, 0));
    // reload of 1: continuous tick while enabled
    vecs.push_back(mk("r1_load", 0, 1, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk("r1_t1",   0, 0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk("r1_t2",   0, 0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk("r1_off",  0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk("r1_t3",   0, 0, 0, 1, 1, 1, 1, 1));
    // auto_reload only matters on the terminal edge
    vecs.push_back(mk("s_load",  0, 1, 2, 0, 0, 2, 0, 1));
    vecs.push_back(mk("s_dec",   0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk("s_tick",  0, 0, 0, 1, 1, 2, 1, 1));
    vecs.push_back(mk("s_dec2",  0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk("s_term",  0, 0, 0, 1, 0, 0, 1, 0));
    // restart during RUN, then clear to IDLE
    vecs.push_back(mk("rs_load5",0, 1, 5, 0, 0, 5, 0, 1));
    vecs.push_back(mk("rs_dec",  0, 0, 0, 1, 0, 4, 0, 1));
    vecs.push_back(mk("rs_load3",0, 1, 3, 1, 0, 3, 0, 1));
    vecs.push_back(mk("c_clear", 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_idle",  0, 0, 0, 1, 0, 0, 0, 0));

    #12;
    check_outs("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].val, vecs[i].en, vecs[i].ar);
      check_outs(vecs[i].name, vecs[i].e_cnt, vecs[i].e_zero, vecs[i].e_busy);
    end

    // full range: 15 enabled edges to terminal, then 10 ignored enables
    drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    check_outs("max_load", 4'd15, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check_outs($sformatf("max_%0d", i), 4'(15 - i), (i == 15), (i != 15));
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check_outs($sformatf("done_%0d", i), 4'd0, 1'b1, 1'b0);
    end

    // asynchronous reset mid-count, away from any clock edge
    drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check_outs("pre_rst", 4'd5, 1'b0, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check_outs("async_rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check_outs("post_rst", 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
